bus_interface_buffer: RTL and testbench
=======================================

// Module: bus_interface_buffer
// PURPOSE
//  Clocked, parametrised successor to the PIC data bus buffer. Synchronises the
//  asynchronous CPU strobes (cs_n/rd_n/wr_n) and queues CPU writes in a DEPTH-entry
//  FIFO of {addr,data} for the internal control logic. It also runs CPU reads as a
//  req/ack transaction and drives a split, tri-state-ready data bus (dout+oe).
// PARAMETERS
//  DATA_W       8  data bus width
//  ADDR_W       1  register-select width (A0 in the 8259A case)
//  DEPTH        4  write FIFO entries; power of two, >=2
//  SYNC_STAGES  2  flops per strobe synchroniser, >=2
// PORTS
//  clk          in   1                  system clock, all logic on rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  cs_n         in   1                  CPU chip select (async)
//  rd_n         in   1                  CPU read strobe (async)
//  wr_n         in   1                  CPU write strobe (async)
//  addr         in   ADDR_W             CPU register select
//  bus_din      in   DATA_W             CPU data toward block
//  bus_dout     out  DATA_W             read data toward CPU
//  bus_oe       out  1                  1 = drive bus_dout onto CPU bus
//  wr_valid     out  1                  FIFO head valid
//  wr_addr      out  ADDR_W             FIFO head address
//  wr_data      out  DATA_W             FIFO head data
//  wr_ready     in   1                  internal logic pops head when valid&ready
//  rd_req       out  1                  one-cycle read request pulse
//  rd_addr      out  ADDR_W             address for rd_req, held until rd_ack
//  rd_data      in   DATA_W             internal read data, valid with rd_ack
//  rd_ack       in   1                  read data strobe
//  fifo_count   out  $clog2(DEPTH)+1    entries held
//  overflow     out  1                  sticky: write dropped on full FIFO
//  clr_overflow in   1                  clears overflow
//  busy         out  1                  read FSM not IDLE or wr_valid
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; FIFO empty, pointers 0; read FSM IDLE;
//   synchroniser flops preset to 1 (strobes inactive).
//  Sync: cs_n/rd_n/wr_n each pass SYNC_STAGES flops -> cs_s, rd_s, wr_s.
//  Write capture: each cycle with wr_s=0 and cs_s=0, addr/bus_din load a shadow reg.
//   A wr_s 0->1 edge with cs_s=0 in the prior cycle pushes the shadow. CPU holds
//   addr/data stable for the whole wr_n low time (>= SYNC_STAGES+2 clk).
//  FIFO: wr_valid = (fifo_count!=0), head on wr_addr/wr_data; no bypass, so a push
//   into empty shows wr_valid the next cycle. Pop on wr_valid&wr_ready. Pointers
//   wrap modulo DEPTH.
//  Full: push with no pop -> entry dropped, overflow<=1, FIFO contents unchanged.
//   Push+pop same cycle when full -> both happen, count stays DEPTH, no overflow.
//  overflow: set wins over clr_overflow in the same cycle.
//  Read FSM (IDLE, REQ, HOLD, DRAIN):
//   IDLE: rd_s 1->0 with cs_s=0 -> rd_req=1 for 1 cycle, rd_addr<=addr -> REQ.
//   REQ: rd_ack is honoured from the cycle after rd_req. On rd_ack, latch
//    rd_data->bus_dout -> HOLD. If rd_s=1 or cs_s=1 before ack -> DRAIN.
//   DRAIN: wait rd_ack, discard data, bus_dout unchanged -> IDLE.
//   HOLD: bus_oe=1 (registered, first cycle after ack). rd_s=1 or cs_s=1 ->
//    bus_oe=0 on the same edge -> IDLE.
//  bus_oe is 1 only in HOLD. bus_dout holds its last value; it is 0 after reset.
//  rd_ack in IDLE/HOLD is ignored.
//  Read and write paths are independent: a write edge during a read is still
//   pushed, and rd_s+wr_s both low is a CPU error but corrupts no state.
//  Reset mid-read: bus_oe drops asynchronously and the pending ack is forgotten.
// TESTING
//  Reset: assert rst_n=0 in HOLD -> bus_oe=0 at once, fifo_count=0, overflow=0.
//  Write addr=1 data=8'h55 -> wr_valid rises <=SYNC_STAGES+2 clk after wr_n rise,
//   wr_addr=1, wr_data=8'h55; wr_ready=1 for 1 clk -> fifo_count 0.
//  DEPTH=4, wr_ready=0, write 11,22,33,44,55 -> count=4, overflow=1; drain yields
//   11,22,33,44 in order; clr_overflow -> overflow=0; 6 more writes test wrap.
//  Full FIFO, push and pop same cycle -> count stays 4, overflow stays 0, order OK.
//  Read addr=0, rd_ack 3 clk after rd_req with rd_data=8'h66 -> one rd_req pulse,
//   rd_addr=0, bus_oe=1 with bus_dout=8'h66 until synced rd_n rise, then 0.
//  rd_n released before rd_ack -> DRAIN; bus_oe never 1; IDLE after ack.

Source files
------------

// File: rtl/bus_interface_buffer.sv
// CPU-side bus buffer: strobe synchronisers, a write FIFO of {addr,data} toward
// the internal logic, and a req/ack read engine driving a split tri-state-ready bus.
module bus_interface_buffer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs_n,
    input  logic                      rd_n,
    input  logic                      wr_n,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         bus_din,
    output logic [DATA_W-1:0]         bus_dout,
    output logic                      bus_oe,
    output logic                      wr_valid,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_ready,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic                      rd_ack,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    input  logic                      clr_overflow,
    output logic                      busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} rd_state_t;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
    logic                   cs_s, rd_s, wr_s;
    logic                   cs_s_d, rd_s_d, wr_s_d;

    logic [ADDR_W-1:0]        shadow_addr;
    logic [DATA_W-1:0]        shadow_data;
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic                     push, pop, full, push_ok, drop;

    rd_state_t state;
    logic      rd_start, rd_abort;

    // Strobes are inactive-high, so synchronisers come out of reset at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            cs_s_d  <= 1'b1;
            rd_s_d  <= 1'b1;
            wr_s_d  <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd_n};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_n};
            cs_s_d  <= cs_s;
            rd_s_d  <= rd_s;
            wr_s_d  <= wr_s;
        end
    end

    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign rd_s = rd_sync[SYNC_STAGES-1];
    assign wr_s = wr_sync[SYNC_STAGES-1];

    // cs is checked one cycle back so a CPU releasing cs_n with wr_n still counts.
    assign push     = wr_s & ~wr_s_d & ~cs_s_d;
    assign wr_valid = (fifo_count != '0);
    assign pop      = wr_valid & wr_ready;
    assign full     = (fifo_count == CNT_W'(DEPTH));
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;

    assign {wr_addr, wr_data} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_addr <= '0;
            shadow_data <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (!wr_s && !cs_s) begin
                shadow_addr <= addr;
                shadow_data <= bus_din;
            end
            if (push_ok) begin
                mem[wr_ptr] <= {shadow_addr, shadow_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    assign rd_start = rd_s_d & ~rd_s & ~cs_s;
    assign rd_abort = rd_s | cs_s;

    // An ack during the rd_req cycle itself is too early to belong to this request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            bus_dout <= '0;
            bus_oe   <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        rd_req  <= 1'b1;
                        rd_addr <= addr;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (rd_ack && !rd_req) begin
                        bus_dout <= rd_data;
                        bus_oe   <= 1'b1;
                        state    <= HOLD;
                    end else if (rd_abort) begin
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (rd_abort) begin
                        bus_oe <= 1'b0;
                        state  <= IDLE;
                    end
                end
                DRAIN: begin
                    if (rd_ack) state <= IDLE;
                end
                default: begin
                    bus_oe <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) | wr_valid;

endmodule

// File: tb/tb_bus_interface_buffer.sv
// Directed self-checking bench for bus_interface_buffer: reset, write FIFO
// (overflow, wrap, full push+pop) and the read req/ack/drain paths.
module tb_bus_interface_buffer;

    logic       clk, rst_n;
    logic       cs_n, rd_n, wr_n;
    logic [0:0] addr;
    logic [7:0] bus_din, bus_dout;
    logic       bus_oe;
    logic       wr_valid;
    logic [0:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic [0:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_ack;
    logic [2:0] fifo_count;
    logic       overflow, clr_overflow, busy;

    int total = 0;
    int bad = 0;
    int rd_req_cnt = 0;
    bit oe_seen = 0;

    bus_interface_buffer #(.DATA_W(8), .ADDR_W(1), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
        .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_req) rd_req_cnt++;
        if (bus_oe) oe_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Full CPU write cycle; optionally raises wr_ready for exactly the push cycle.
    task automatic applyStimulus(input logic [0:0] a, input logic [7:0] d,
                                 input bit pop_on_push, output int lat);
        logic [2:0] cnt0;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; bus_din = d;
        repeat (5) @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        cnt0 = fifo_count;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 2 && pop_on_push) wr_ready = 1'b1;
            if (i == 3) wr_ready = 1'b0;
            if (lat == 0 && fifo_count != cnt0) lat = i;
        end
    endtask

    task automatic popOne();
        @(negedge clk); wr_ready = 1'b1;
        @(negedge clk); wr_ready = 1'b0;
    endtask

    task automatic readToReq(input logic [0:0] a);
        bit found;
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; addr = a;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rd_req) begin found = 1'b1; break; end
        end
        checkOutput("rd_req_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic ackAfter3(input logic [7:0] d);
        repeat (3) @(negedge clk);
        rd_ack = 1'b1; rd_data = d;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    int lat;
    int req0;
    logic [7:0] exp_q[$];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = '0;
        bus_din = '0; wr_ready = 1'b0; rd_data = '0; rd_ack = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_oe", bus_oe, 0);
        checkOutput("rst_dout", bus_dout, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_valid", wr_valid, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rdreq", rd_req, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write, latency and pop
        applyStimulus(1'b1, 8'h55, 1'b0, lat);
        checkOutput("wr_lat_ok", (lat >= 1 && lat <= 4), 1);
        checkOutput("wr_valid", wr_valid, 1);
        checkOutput("wr_addr", wr_addr, 1);
        checkOutput("wr_data", wr_data, 8'h55);
        checkOutput("busy_wr", busy, 1);
        popOne();
        checkOutput("pop_count", fifo_count, 0);
        checkOutput("pop_valid", wr_valid, 0);

        // overflow
        for (int i = 1; i <= 4; i++) applyStimulus(1'(i % 2), 8'(8'h11 * i), 1'b0, lat);
        checkOutput("fill_count", fifo_count, 4);
        checkOutput("fill_ovf", overflow, 0);
        applyStimulus(1'b1, 8'h55, 1'b0, lat);
        checkOutput("ovf_count", fifo_count, 4);
        checkOutput("ovf_set", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_data", wr_data, 8'h11 * i);
            checkOutput("drain_addr", wr_addr, i % 2);
            popOne();
        end
        checkOutput("drain_count", fifo_count, 0);
        checkOutput("ovf_sticky", overflow, 1);
        @(negedge clk); clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        checkOutput("ovf_clr", overflow, 0);

        // wrap: 3 in, 3 out, 3 in (pointers wrap), 3 out
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) applyStimulus(1'(i % 2), 8'(8'hA0 + 3 * r + i), 1'b0, lat);
            checkOutput("wrap_count", fifo_count, 3);
            for (int i = 0; i < 3; i++) begin
                checkOutput("wrap_data", wr_data, 8'hA0 + 3 * r + i);
                popOne();
            end
        end
        checkOutput("wrap_empty", fifo_count, 0);

        // full FIFO with push and pop in the same cycle
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 8'(8'hB0 + i), 1'b0, lat);
        applyStimulus(1'b1, 8'hB5, 1'b1, lat);
        checkOutput("pp_count", fifo_count, 4);
        checkOutput("pp_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            checkOutput("pp_data", wr_data, 8'hB0 + i);
            popOne();
        end

        // normal read
        req0 = rd_req_cnt;
        oe_seen = 1'b0;
        readToReq(1'b0);
        checkOutput("rd_addr", rd_addr, 0);
        @(negedge clk);
        checkOutput("rd_req_pulse", rd_req, 0);
        ackAfter3(8'h66);
        checkOutput("rd_oe", bus_oe, 1);
        checkOutput("rd_dout", bus_dout, 8'h66);
        repeat (2) @(negedge clk);
        checkOutput("rd_oe_hold", bus_oe, 1);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rd_oe_off", bus_oe, 0);
        checkOutput("rd_dout_keep", bus_dout, 8'h66);
        checkOutput("rd_idle", busy, 0);
        checkOutput("rd_one_req", rd_req_cnt - req0, 1);

        // ack while idle is ignored
        @(negedge clk); rd_ack = 1'b1; rd_data = 8'h77;
        @(negedge clk); rd_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack_dout", bus_dout, 8'h66);
        checkOutput("idle_ack_busy", busy, 0);

        // aborted read drains
        oe_seen = 1'b0;
        readToReq(1'b1);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("drain_busy", busy, 1);
        rd_ack = 1'b1; rd_data = 8'h99;
        @(negedge clk); rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("drain_idle", busy, 0);
        checkOutput("drain_dout", bus_dout, 8'h66);
        checkOutput("drain_no_oe", oe_seen, 0);

        // reset while holding read data with a full, overflowed FIFO
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 8'(i), 1'b0, lat);
        checkOutput("pre_rst_ovf", overflow, 1);
        readToReq(1'b0);
        ackAfter3(8'hAB);
        checkOutput("pre_rst_oe", bus_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_oe", bus_oe, 0);
        checkOutput("arst_count", fifo_count, 0);
        checkOutput("arst_ovf", overflow, 0);
        checkOutput("arst_dout", bus_dout, 0);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
